// File: rtl/fetch_issue_unit.sv
// Fetch/issue stage: owns the PC, issues fetched words or NOP bubbles into the ID register,
// and keeps the issued-instruction history used by the pre-decoder hazard checks.
module fetch_issue_unit #(
   parameter int ISIZE = 16,
   parameter int ASIZE = 8,
   parameter logic [ISIZE-1:0] NOP_INSTR = 16'h7000,
   parameter logic [ISIZE-1:0] HALT_INSTR = 16'hFFFF
) (
   input  logic             clk,
   input  logic             rst,
   output logic [ASIZE-1:0] imem_addr,
   input  logic [ISIZE-1:0] imem_rdata,
   output logic [ISIZE-1:0] Instr,
   input  logic             PC_En,
   input  logic             instr_sel,
   input  logic             hold,
   input  logic             redirect_valid,
   input  logic [ASIZE-1:0] redirect_pc,
   output logic [ISIZE-1:0] LastInstr,
   output logic [ISIZE-1:0] Last3Instr,
   output logic [ISIZE-1:0] id_instr,
   output logic [ASIZE-1:0] id_pc,
   output logic             id_valid,
   output logic             halted,
   output logic [15:0]      bubble_cnt
);

   typedef enum logic {RUN, HALTED} state_t;

   state_t           state_q, state_d;
   logic [ASIZE-1:0] pc_q, pc_d;
   logic [ASIZE-1:0] id_pc_q, id_pc_d;
   logic             id_valid_q, id_valid_d;
   logic [ISIZE-1:0] h1_q, h1_d;
   logic [ISIZE-1:0] h2_q, h2_d;
   logic [ISIZE-1:0] h3_q, h3_d;
   logic [15:0]      bubble_cnt_q, bubble_cnt_d;
   logic             issue_bubble;
   logic [ASIZE-1:0] pc_inc;

   assign pc_inc = pc_q + {{(ASIZE-1){1'b0}}, 1'b1};

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      id_pc_d      = id_pc_q;
      id_valid_d   = id_valid_q;
      h1_d         = h1_q;
      h2_d         = h2_q;
      h3_d         = h3_q;
      bubble_cnt_d = bubble_cnt_q;
      issue_bubble = 1'b0;

      // A held edge is not an issue slot, so the history only shifts when not held.
      if (!hold) begin
         h3_d = h2_q;
         h2_d = h1_q;
         if (redirect_valid) begin
            pc_d         = redirect_pc;
            state_d      = RUN;
            issue_bubble = 1'b1;
         end else if (state_q == HALTED) begin
            issue_bubble = 1'b1;
         end else if (instr_sel) begin
            issue_bubble = 1'b1;
            if (PC_En) begin
               pc_d = pc_inc;
            end
         end else begin
            h1_d       = imem_rdata;
            id_valid_d = 1'b1;
            id_pc_d    = pc_q;
            if (imem_rdata == HALT_INSTR) begin
               state_d = HALTED;
            end else if (PC_En) begin
               pc_d = pc_inc;
            end
         end

         if (issue_bubble) begin
            h1_d       = NOP_INSTR;
            id_valid_d = 1'b0;
            id_pc_d    = pc_q;
            if (bubble_cnt_q != 16'hFFFF) begin
               bubble_cnt_d = bubble_cnt_q + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= RUN;
         pc_q         <= '0;
         id_pc_q      <= '0;
         id_valid_q   <= 1'b0;
         h1_q         <= NOP_INSTR;
         h2_q         <= NOP_INSTR;
         h3_q         <= NOP_INSTR;
         bubble_cnt_q <= 16'd0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         id_pc_q      <= id_pc_d;
         id_valid_q   <= id_valid_d;
         h1_q         <= h1_d;
         h2_q         <= h2_d;
         h3_q         <= h3_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign imem_addr  = pc_q;
   assign Instr      = imem_rdata;
   assign id_instr   = h1_q;
   assign LastInstr  = h1_q;
   assign Last3Instr = h3_q;
   assign id_pc      = id_pc_q;
   assign id_valid   = id_valid_q;
   assign halted     = (state_q == HALTED);
   assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_fetch_issue_unit.sv
// Directed vector bench for fetch_issue_unit: one cycle per table row, each row
// holding the inputs driven before an edge and the outputs required after it.
module tb_fetch_issue_unit;

   logic        clk;
   logic        rst;
   logic [7:0]  imem_addr;
   logic [15:0] imem_rdata;
   logic [15:0] Instr;
   logic        PC_En;
   logic        instr_sel;
   logic        hold;
   logic        redirect_valid;
   logic [7:0]  redirect_pc;
   logic [15:0] LastInstr;
   logic [15:0] Last3Instr;
   logic [15:0] id_instr;
   logic [7:0]  id_pc;
   logic        id_valid;
   logic        halted;
   logic [15:0] bubble_cnt;

   logic [15:0] mem [256];

   int checkCount = 0;
   int passCount  = 0;

   typedef struct {
      logic        rst;
      logic        pcEn;
      logic        instrSel;
      logic        hold;
      logic        redirValid;
      logic [7:0]  redirPc;
      logic [15:0] expInstr;
      logic [7:0]  expIdPc;
      logic        expValid;
      logic [7:0]  expAddr;
      logic        expHalted;
      logic [15:0] expCnt;
      logic [15:0] expLast3;
   } vec_t;

   vec_t vecs[$];

   fetch_issue_unit dut (
      .clk            (clk),
      .rst            (rst),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .Instr          (Instr),
      .PC_En          (PC_En),
      .instr_sel      (instr_sel),
      .hold           (hold),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .LastInstr      (LastInstr),
      .Last3Instr     (Last3Instr),
      .id_instr       (id_instr),
      .id_pc          (id_pc),
      .id_valid       (id_valid),
      .halted         (halted),
      .bubble_cnt     (bubble_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory is a combinational read of the current PC.
   assign imem_rdata = mem[imem_addr];

   function automatic vec_t mk(input logic r, input logic pe, input logic sel, input logic hd,
                               input logic rv, input logic [7:0] rpc,
                               input logic [15:0] eI, input logic [7:0] ePc, input logic eV,
                               input logic [7:0] eA, input logic eH, input logic [15:0] eC,
                               input logic [15:0] eL3);
      vec_t v;
      v.rst = r; v.pcEn = pe; v.instrSel = sel; v.hold = hd;
      v.redirValid = rv; v.redirPc = rpc;
      v.expInstr = eI; v.expIdPc = ePc; v.expValid = eV; v.expAddr = eA;
      v.expHalted = eH; v.expCnt = eC; v.expLast3 = eL3;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      rst            = v.rst;
      PC_En          = v.pcEn;
      instr_sel      = v.instrSel;
      hold           = v.hold;
      redirect_valid = v.redirValid;
      redirect_pc    = v.redirPc;
      @(posedge clk);
      #1;
   endtask

   task automatic checkVector(input int idx, input vec_t v);
      string tag;
      tag = $sformatf("v%0d", idx);
      checkOutput({tag, ".id_instr"},   32'(id_instr),   32'(v.expInstr));
      checkOutput({tag, ".LastInstr"},  32'(LastInstr),  32'(v.expInstr));
      checkOutput({tag, ".id_pc"},      32'(id_pc),      32'(v.expIdPc));
      checkOutput({tag, ".id_valid"},   32'(id_valid),   32'(v.expValid));
      checkOutput({tag, ".imem_addr"},  32'(imem_addr),  32'(v.expAddr));
      checkOutput({tag, ".halted"},     32'(halted),     32'(v.expHalted));
      checkOutput({tag, ".bubble_cnt"}, 32'(bubble_cnt), 32'(v.expCnt));
      checkOutput({tag, ".Last3Instr"}, 32'(Last3Instr), 32'(v.expLast3));
      checkOutput({tag, ".Instr"},      32'(Instr),      32'(mem[v.expAddr]));
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h0100 + 16'(i);
      mem[0] = 16'h1234;
      mem[1] = 16'h2345;
      mem[2] = 16'h3456;
      mem[3] = 16'hFFFF;

      rst = 1'b1; PC_En = 1'b0; instr_sel = 1'b0; hold = 1'b0;
      redirect_valid = 1'b0; redirect_pc = 8'h00;

      //            rst pe sel hd rv rpc     id_instr  idpc  v  addr  h  cnt  last3
      // reset held two cycles, then straight-line fetch into the HALT at address 3
      vecs.push_back(mk(1, 1, 0, 0, 0, 8'h00, 16'h7000, 8'h00, 0, 8'h00, 0, 16'd0, 16'h7000));
      vecs.push_back(mk(1, 1, 0, 0, 0, 8'h00, 16'h7000, 8'h00, 0, 8'h00, 0, 16'd0, 16'h7000));
      vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 16'h1234, 8'h00, 1, 8'h01, 0, 16'd0, 16'h7000));
      vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 16'h2345, 8'h01, 1, 8'h02, 0, 16'd0, 16'h7000));
      vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 16'h3456, 8'h02, 1, 8'h03, 0, 16'd0, 16'h1234));
      vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 16'hFFFF, 8'h03, 1, 8'h03, 1, 16'd0, 16'h2345));
      vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 16'h7000, 8'h03, 0, 8'h03, 1, 16'd1, 16'h3456));
      vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 16'h7000, 8'h03, 0, 8'h03, 1, 16'd2, 16'hFFFF));
      // redirect leaves HALTED, then a redirect from 0x10 to 0x40
      vecs.push_back(mk(0, 1, 0, 0, 1, 8'h10, 16'h7000, 8'h03, 0, 8'h10, 0, 16'd3, 16'h7000));
      vecs.push_back(mk(0, 1, 0, 0, 1, 8'h40, 16'h7000, 8'h10, 0, 8'h40, 0, 16'd4, 16'h7000));
      vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 16'h0140, 8'h40, 1, 8'h41, 0, 16'd4, 16'h7000));
      // load-use stall at PC 5, then a re-fetch with PC_En low
      vecs.push_back(mk(0, 1, 0, 0, 1, 8'h05, 16'h7000, 8'h41, 0, 8'h05, 0, 16'd5, 16'h7000));
      vecs.push_back(mk(0, 0, 1, 0, 0, 8'h00, 16'h7000, 8'h05, 0, 8'h05, 0, 16'd6, 16'h0140));
      vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 16'h0105, 8'h05, 1, 8'h06, 0, 16'd6, 16'h7000));
      vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 16'h0106, 8'h06, 1, 8'h06, 0, 16'd6, 16'h7000));
      // hold beats a simultaneous redirect
      vecs.push_back(mk(0, 1, 0, 1, 1, 8'h20, 16'h0106, 8'h06, 1, 8'h06, 0, 16'd6, 16'h7000));
      // jump to 0xFF, hold three cycles, then wrap to 0
      vecs.push_back(mk(0, 1, 0, 0, 1, 8'hFF, 16'h7000, 8'h06, 0, 8'hFF, 0, 16'd7, 16'h0105));
      vecs.push_back(mk(0, 1, 0, 1, 0, 8'h00, 16'h7000, 8'h06, 0, 8'hFF, 0, 16'd7, 16'h0105));
      vecs.push_back(mk(0, 1, 0, 1, 0, 8'h00, 16'h7000, 8'h06, 0, 8'hFF, 0, 16'd7, 16'h0105));
      vecs.push_back(mk(0, 1, 0, 1, 0, 8'h00, 16'h7000, 8'h06, 0, 8'hFF, 0, 16'd7, 16'h0105));
      vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 16'h01FF, 8'hFF, 1, 8'h00, 0, 16'd7, 16'h0106));
      // mid-run reset, then a redirect squashing a fetched HALT
      vecs.push_back(mk(1, 1, 0, 0, 0, 8'h00, 16'h7000, 8'h00, 0, 8'h00, 0, 16'd0, 16'h7000));
      vecs.push_back(mk(0, 1, 0, 0, 1, 8'h03, 16'h7000, 8'h00, 0, 8'h03, 0, 16'd1, 16'h7000));
      vecs.push_back(mk(0, 1, 0, 0, 1, 8'h40, 16'h7000, 8'h03, 0, 8'h40, 0, 16'd2, 16'h7000));
      vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 16'h0140, 8'h40, 1, 8'h41, 0, 16'd2, 16'h7000));
      // reset while HALTED returns to RUN
      vecs.push_back(mk(0, 1, 0, 0, 1, 8'h03, 16'h7000, 8'h41, 0, 8'h03, 0, 16'd3, 16'h7000));
      vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 16'hFFFF, 8'h03, 1, 8'h03, 1, 16'd3, 16'h0140));
      vecs.push_back(mk(1, 1, 0, 0, 0, 8'h00, 16'h7000, 8'h00, 0, 8'h00, 0, 16'd0, 16'h7000));

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         checkVector(i, vecs[i]);
      end

      // Stall with PC_En low and instr_sel low for several cycles: the same word
      // is re-issued valid each edge while the bubble count stays put.
      rst = 1'b0; PC_En = 1'b1; instr_sel = 1'b0; hold = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 8'h80;
      @(posedge clk); #1;
      checkOutput("seq.redir_addr", 32'(imem_addr), 32'h80);
      redirect_valid = 1'b0; PC_En = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         checkOutput($sformatf("seq.refetch%0d.instr", k), 32'(id_instr), 32'h0180);
         checkOutput($sformatf("seq.refetch%0d.addr", k), 32'(imem_addr), 32'h80);
         checkOutput($sformatf("seq.refetch%0d.cnt", k), 32'(bubble_cnt), 32'd1);
      end
      checkOutput("seq.last3", 32'(Last3Instr), 32'h0180);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
